uart_cmd_parser: RTL and testbench
==================================

Name: uart_cmd_parser

Overview:
- Sits directly downstream of the UART byte receiver. It consumes `rx_data[7:0]` together with the one-cycle `po_flag` strobe, and parses a fixed host command frame.
- Frame format: `HDR`, `CMD`, `ADDR[23:16]`, `ADDR[15:8]`, `ADDR[7:0]`, `LEN`, followed by `LEN` payload bytes for writes only.
- Outputs: SDRAM read/write requests (address and length), plus a byte stream of write payload for the SDRAM write FIFO.
- Aborts malformed or stalled frames and reports them with an error pulse.

Parameters:
- `HDR_BYTE`, `8'h55`, frame header value.
- `CMD_WR`, `8'h01`, write command code.
- `CMD_RD`, `8'h02`, read command code.
- `TIMEOUT_CYC`, `156250`, maximum idle cycles between bytes inside a frame (3 byte-times at 9600 baud, 50 MHz); simulation builds use `300`.
- `TMO_W`, `18`, width of the timeout counter; must satisfy 2^`TMO_W` > `TIMEOUT_CYC`.

Ports:
- `sclk`  in  1  system clock, 50 MHz.
- `s_rst`  in  1  synchronous reset, active-high.
- `rx_data`  in  8  received byte; valid only in the `po_flag` cycle.
- `po_flag`  in  1  one-cycle strobe, byte valid.
- `cmd_addr`  out  24  latched frame address.
- `cmd_len`  out  8  latched frame length, 1..255.
- `rd_trig`  out  1  one-cycle pulse: read request; `cmd_addr`/`cmd_len` valid.
- `wr_trig`  out  1  one-cycle pulse: write request start; `cmd_addr`/`cmd_len` valid.
- `wr_data`  out  8  payload byte.
- `wr_data_vld`  out  1  one-cycle pulse per payload byte.
- `wr_done`  out  1  one-cycle pulse with the last payload byte.
- `frame_err`  out  1  one-cycle pulse on frame abort.
- `busy`  out  1  high whenever the state is not `IDLE`.

Behaviour:
- All outputs are registered. Reset values: every output is 0, `state` = `IDLE`, timer = 0, byte counter = 0.
- Latency: every response appears exactly 1 cycle after the `po_flag` cycle that causes it.
- States: `IDLE`, `CMD`, `ADR2`, `ADR1`, `ADR0`, `LEN`, `DATA`. All transitions advance only on `po_flag`, except timeout.
- `IDLE`:
  - byte == `HDR_BYTE` → `CMD`.
  - Any other byte is silently discarded, with no error.
- `CMD`:
  - byte == `CMD_WR` or `CMD_RD` → latch the command type, go to `ADR2`.
  - Otherwise pulse `frame_err` and go to `IDLE`.
- `ADR2` / `ADR1` / `ADR0`: load `cmd_addr[23:16]`, `[15:8]`, `[7:0]` respectively, then advance.
- `LEN`:
  - byte == 0 → pulse `frame_err`, go to `IDLE`.
  - Read command → latch `cmd_len`, pulse `rd_trig`, go to `IDLE`.
  - Write command → latch `cmd_len`, pulse `wr_trig`, load the byte counter with `LEN`, go to `DATA`.
- `DATA`:
  - Each byte: `wr_data` ← byte, pulse `wr_data_vld`, decrement the counter.
  - When the counter was 1: also pulse `wr_done`, go to `IDLE`.
- `cmd_addr` and `cmd_len` hold their values until the next frame overwrites them. They are stable from the cycle of the trig pulse through the end of that frame.
- Header byte seen in a non-`IDLE` state: treated as ordinary data, with no resync. For example, 0x55 is a legal address or payload byte.
- Timeout counter:
  - Clears on every `po_flag` and while in `IDLE`; increments otherwise.
  - On reaching `TIMEOUT_CYC-1`: pulse `frame_err`, go to `IDLE`.
  - If `po_flag` arrives in the same cycle as expiry, the byte wins: it is processed normally and the timer clears.
- No backpressure. The downstream FIFO must accept one byte per `wr_data_vld`. Bytes arrive at most one per ~52k cycles, so no overflow is possible inside this block.
- `s_rst` mid-frame: `state` is forced to `IDLE` and all pulses are cleared. No `frame_err` or `wr_done` is emitted for the aborted frame.
- `busy` = (`state` != `IDLE`), registered alongside `state`.

Decomposition:
- Shared package `uart_pkg`:
  - Frame constants `HDR_BYTE`, `CMD_WR`, `CMD_RD`.
  - State encoding localparams (binary, 3 bits).
  - Baud-derived constants: `BAUD_END`, and `TIMEOUT_CYC` under `SIM`.
- One sub-module: `frame_timer`, the inter-byte timeout counter.
  - Inputs: `sclk`, `s_rst`, `clr` (= `po_flag` | `IDLE`).
  - Output: `expire` pulse.
- The FSM and datapath stay in `uart_cmd_parser`.

Test Plan:
- Read frame: bytes 55 02 12 34 56 10 → one `rd_trig` 1 cycle after the last strobe; `cmd_addr` = 0x123456, `cmd_len` = 0x10; `busy` falls to 0; no `wr_*` activity.
- Write frame: 55 01 00 00 08 03 AA 55 0F → `wr_trig` with `cmd_addr` = 0x000008, `cmd_len` = 3. Then `wr_data_vld` ×3 carrying AA, 55, 0F. `wr_done` coincides with 0F.
- Garbage and bad command:
  - 13 77 in `IDLE` → no outputs.
  - Then 55 03 → `frame_err` pulse and return to `IDLE`.
  - Then 55 02 00 00 00 00 (LEN = 0) → `frame_err`; no `rd_trig`.
- Timeout: 55 01 00 00 00 04 AA, then silence → after exactly `TIMEOUT_CYC` cycles from the AA strobe, `frame_err` pulses and `busy` = 0. A following valid read frame is parsed correctly.
- Boundary: send 55 at exactly cycle `TIMEOUT_CYC-1` after the previous strobe → byte accepted, no `frame_err`. `LEN` = 0xFF write frame → 255 `wr_data_vld` pulses, `wr_done` on the 255th only.
- Reset mid-frame: assert `s_rst` for 1 cycle during `ADR1` → all outputs 0, `busy` = 0, no `frame_err`. The next full write frame behaves as in the write-frame scenario.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: frame constants, state encoding and baud-derived timing shared by the command parser.
package uart_pkg;
  localparam logic [7:0] HDR_BYTE = 8'h55;
  localparam logic [7:0] CMD_WR   = 8'h01;
  localparam logic [7:0] CMD_RD   = 8'h02;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CMD  = 3'd1;
  localparam logic [2:0] S_ADR2 = 3'd2;
  localparam logic [2:0] S_ADR1 = 3'd3;
  localparam logic [2:0] S_ADR0 = 3'd4;
  localparam logic [2:0] S_LEN  = 3'd5;
  localparam logic [2:0] S_DATA = 3'd6;
  typedef enum logic [2:0] {
    IDLE = S_IDLE, CMD = S_CMD, ADR2 = S_ADR2, ADR1 = S_ADR1,
    ADR0 = S_ADR0, LEN = S_LEN, DATA = S_DATA
  } state_t;
  localparam int BAUD_END = 5207;
`ifdef SIM
  localparam int TIMEOUT_CYC = 300;
`else
  localparam int TIMEOUT_CYC = 156250;
`endif
  localparam int TMO_W = 18;
endpackage

// File: rtl/uart_cmd_parser_frame_timer.sv
// frame_timer: inter-byte idle counter; expire flags the cycle the frame has gone stale.
module frame_timer import uart_pkg::*; #(
  parameter int TIMEOUT_CYC = uart_pkg::TIMEOUT_CYC,
  parameter int TMO_W = uart_pkg::TMO_W
) (
  input  logic sclk,
  input  logic s_rst,
  input  logic clr,
  output logic expire
);
  logic [TMO_W-1:0] cnt;
  always_ff @(posedge sclk)
    cnt <= (s_rst || clr) ? '0 : cnt + 1'b1;
  // a byte arriving on the expiry cycle clears the timer and wins
  assign expire = !clr && cnt == TMO_W'(TIMEOUT_CYC - 1);
endmodule

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: parses HDR/CMD/ADDR/LEN(/payload) frames into SDRAM read/write requests.
module uart_cmd_parser import uart_pkg::*; #(
  parameter int TIMEOUT_CYC = uart_pkg::TIMEOUT_CYC,
  parameter int TMO_W = uart_pkg::TMO_W
) (
  input  logic        sclk,
  input  logic        s_rst,
  input  logic [7:0]  rx_data,
  input  logic        po_flag,
  output logic [23:0] cmd_addr,
  output logic [7:0]  cmd_len,
  output logic        rd_trig,
  output logic        wr_trig,
  output logic [7:0]  wr_data,
  output logic        wr_data_vld,
  output logic        wr_done,
  output logic        frame_err,
  output logic        busy
);
  state_t state, state_n;
  logic is_wr, is_wr_n, expire, cmd_ok;
  logic [7:0] cnt, cnt_n, len_n, data_n;
  logic [23:0] addr_n;
  logic rd_n, wr_n, vld_n, done_n, err_n;
  frame_timer #(.TIMEOUT_CYC(TIMEOUT_CYC), .TMO_W(TMO_W)) u_timer (
    .sclk(sclk), .s_rst(s_rst), .clr(po_flag || state == IDLE), .expire(expire)
  );
  assign cmd_ok = rx_data == CMD_WR || rx_data == CMD_RD;
  always_comb begin
    state_n = state;
    is_wr_n = is_wr;
    cnt_n = cnt;
    addr_n = cmd_addr;
    len_n = cmd_len;
    data_n = wr_data;
    rd_n = 1'b0;
    wr_n = 1'b0;
    vld_n = 1'b0;
    done_n = 1'b0;
    err_n = 1'b0;
    if (po_flag) begin
      case (state)
        IDLE: state_n = rx_data == HDR_BYTE ? CMD : IDLE;
        CMD: begin
          is_wr_n = cmd_ok ? rx_data == CMD_WR : is_wr;
          err_n = !cmd_ok;
          state_n = cmd_ok ? ADR2 : IDLE;
        end
        ADR2: begin
          addr_n[23:16] = rx_data;
          state_n = ADR1;
        end
        ADR1: begin
          addr_n[15:8] = rx_data;
          state_n = ADR0;
        end
        ADR0: begin
          addr_n[7:0] = rx_data;
          state_n = LEN;
        end
        LEN: begin
          err_n = rx_data == 8'd0;
          len_n = err_n ? cmd_len : rx_data;
          rd_n = !err_n && !is_wr;
          wr_n = !err_n && is_wr;
          cnt_n = rx_data;
          state_n = wr_n ? DATA : IDLE;
        end
        DATA: begin
          data_n = rx_data;
          vld_n = 1'b1;
          cnt_n = cnt - 1'b1;
          done_n = cnt == 8'd1;
          state_n = done_n ? IDLE : DATA;
        end
        default: state_n = IDLE;
      endcase
    end else if (expire) begin
      err_n = 1'b1;
      state_n = IDLE;
    end
  end
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      state <= IDLE;
      is_wr <= 1'b0;
      cnt <= '0;
      cmd_addr <= '0;
      cmd_len <= '0;
      wr_data <= '0;
      rd_trig <= 1'b0;
      wr_trig <= 1'b0;
      wr_data_vld <= 1'b0;
      wr_done <= 1'b0;
      frame_err <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      is_wr <= is_wr_n;
      cnt <= cnt_n;
      cmd_addr <= addr_n;
      cmd_len <= len_n;
      wr_data <= data_n;
      rd_trig <= rd_n;
      wr_trig <= wr_n;
      wr_data_vld <= vld_n;
      wr_done <= done_n;
      frame_err <= err_n;
      busy <= state_n != IDLE;
    end
  end
endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser: directed frames with hand-computed expectations for uart_cmd_parser.
module tb_uart_cmd_parser;
  localparam int T = 300;
  logic sclk = 1'b0, s_rst, po_flag;
  logic [7:0] rx_data, cmd_len, wr_data;
  logic [23:0] cmd_addr;
  logic rd_trig, wr_trig, wr_data_vld, wr_done, frame_err, busy;
  int checks = 0, errors = 0;
  int rd_cnt = 0, wr_cnt = 0, vld_cnt = 0, done_cnt = 0, err_cnt = 0, done_at = 0;
  logic [7:0] last_data = '0;
  int b_rd, b_wr, b_vld, b_done, b_err;
  uart_cmd_parser #(.TIMEOUT_CYC(T)) dut (
    .sclk(sclk), .s_rst(s_rst), .rx_data(rx_data), .po_flag(po_flag),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .rd_trig(rd_trig), .wr_trig(wr_trig),
    .wr_data(wr_data), .wr_data_vld(wr_data_vld), .wr_done(wr_done),
    .frame_err(frame_err), .busy(busy)
  );
  always #5 sclk = ~sclk;
  always @(posedge sclk) begin
    if (rd_trig) rd_cnt++;
    if (wr_trig) wr_cnt++;
    if (frame_err) err_cnt++;
    if (wr_data_vld) begin
      vld_cnt++;
      last_data = wr_data;
    end
    if (wr_done) begin
      done_cnt++;
      done_at = vld_cnt;
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [7:0] b, input int gap = 0);
    repeat (gap) @(negedge sclk);
    @(negedge sclk);
    rx_data = b;
    po_flag = 1'b1;
    @(negedge sclk);
    po_flag = 1'b0;
  endtask
  task automatic snap;
    repeat (2) @(negedge sclk);
    b_rd = rd_cnt; b_wr = wr_cnt; b_vld = vld_cnt; b_done = done_cnt; b_err = err_cnt;
  endtask
  task automatic write_frame;
    send(8'h55); send(8'h01); send(8'h00); send(8'h00); send(8'h08); send(8'h03);
    chk("wr_trig", wr_trig, 1); chk("wr_addr", cmd_addr, 24'h000008);
    chk("wr_len", cmd_len, 3); chk("wr_busy", busy, 1);
    send(8'hAA);
    chk("vld0", wr_data_vld, 1); chk("data0", wr_data, 8'hAA); chk("done0", wr_done, 0);
    send(8'h55);
    chk("vld1", wr_data_vld, 1); chk("data1", wr_data, 8'h55);
    send(8'h0F);
    chk("vld2", wr_data_vld, 1); chk("data2", wr_data, 8'h0F); chk("done2", wr_done, 1);
    chk("wr_idle", busy, 0); chk("wr_addr_hold", cmd_addr, 24'h000008);
    repeat (2) @(negedge sclk);
    chk("wr_vld_n", vld_cnt - b_vld, 3); chk("wr_done_n", done_cnt - b_done, 1);
    chk("wr_trig_n", wr_cnt - b_wr, 1);
  endtask
  initial begin
    s_rst = 1'b1; po_flag = 1'b0; rx_data = '0;
    repeat (3) @(negedge sclk);
    chk("rst_busy", busy, 0); chk("rst_addr", cmd_addr, 0); chk("rst_len", cmd_len, 0);
    chk("rst_pulses", {rd_trig, wr_trig, wr_data_vld, wr_done, frame_err}, 0);
    chk("rst_data", wr_data, 0);
    s_rst = 1'b0;
    snap;
    send(8'h55);
    chk("rd_busy_hdr", busy, 1);
    send(8'h02); send(8'h12); send(8'h34); send(8'h56); send(8'h10);
    chk("rd_trig", rd_trig, 1); chk("rd_addr", cmd_addr, 24'h123456);
    chk("rd_len", cmd_len, 8'h10); chk("rd_idle", busy, 0); chk("rd_no_wr", wr_trig, 0);
    repeat (2) @(negedge sclk);
    chk("rd_trig_n", rd_cnt - b_rd, 1);
    chk("rd_wr_act", (wr_cnt - b_wr) + (vld_cnt - b_vld), 0);
    snap;
    write_frame;
    snap;
    send(8'h13); send(8'h77);
    chk("garbage_busy", busy, 0);
    repeat (2) @(negedge sclk);
    chk("garbage_err", err_cnt - b_err, 0);
    send(8'h55); send(8'h03);
    chk("badcmd_err", frame_err, 1); chk("badcmd_idle", busy, 0);
    send(8'h55); send(8'h02); send(8'h00); send(8'h00); send(8'h00); send(8'h00);
    chk("len0_err", frame_err, 1); chk("len0_rd", rd_trig, 0); chk("len0_idle", busy, 0);
    repeat (2) @(negedge sclk);
    chk("bad_err_n", err_cnt - b_err, 2); chk("bad_rd_n", rd_cnt - b_rd, 0);
    send(8'h55); send(8'h01); send(8'h00); send(8'h00); send(8'h00); send(8'h04);
    send(8'hAA);
    repeat (T - 1) @(negedge sclk);
    chk("tmo_early_err", frame_err, 0); chk("tmo_early_busy", busy, 1);
    @(negedge sclk);
    chk("tmo_err", frame_err, 1); chk("tmo_idle", busy, 0);
    send(8'h55); send(8'h02); send(8'hAB); send(8'hCD); send(8'hEF); send(8'h07);
    chk("post_tmo_rd", rd_trig, 1); chk("post_tmo_addr", cmd_addr, 24'hABCDEF);
    chk("post_tmo_len", cmd_len, 7);
    snap;
    send(8'h55); send(8'h01);
    send(8'h55, T - 3);
    chk("gap_tm1_busy", busy, 1); chk("gap_tm1_err", frame_err, 0);
    send(8'h00, T - 2);
    chk("gap_t_busy", busy, 1); chk("gap_t_err", frame_err, 0);
    send(8'h01); send(8'hFF);
    chk("ff_trig", wr_trig, 1); chk("ff_addr", cmd_addr, 24'h550001); chk("ff_len", cmd_len, 8'hFF);
    for (int i = 0; i < 255; i++) send(8'(i));
    chk("ff_done", wr_done, 1); chk("ff_idle", busy, 0);
    repeat (2) @(negedge sclk);
    chk("ff_vld_n", vld_cnt - b_vld, 255); chk("ff_done_n", done_cnt - b_done, 1);
    chk("ff_done_at", done_at - b_vld, 255); chk("ff_last", last_data, 8'hFE);
    chk("ff_err_n", err_cnt - b_err, 0);
    snap;
    send(8'h55); send(8'h01); send(8'h12);
    @(negedge sclk) s_rst = 1'b1;
    @(negedge sclk) s_rst = 1'b0;
    chk("mid_rst_busy", busy, 0); chk("mid_rst_addr", cmd_addr, 0);
    chk("mid_rst_pulses", {rd_trig, wr_trig, wr_data_vld, wr_done, frame_err}, 0);
    repeat (T + 5) @(negedge sclk);
    chk("mid_rst_err_n", err_cnt - b_err, 0); chk("mid_rst_done_n", done_cnt - b_done, 0);
    snap;
    write_frame;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
